fir_sop_pipe: RTL and testbench

Parametrised, pipelined direct-form FIR filter. It generalises the two-tap sum-of-products stage to TAPS taps with a shared sample delay line, writable coefficient registers, a valid handshake and a full-precision registered output. It sits in the datapath directly after the input register level and feeds the output/accumulator level.

---
 rtl/fir_sop_pipe.sv | 58 +++++
 tb/tb_fir_sop_pipe.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fir_sop_pipe.sv
// fir_sop_pipe: pipelined direct-form FIR, writable coefficients, 2-cycle valid pipe
module fir_sop_pipe #(
  parameter int WIDTH = 4,
  parameter int TAPS = 4,
  localparam int AW = $clog2(TAPS),
  localparam int OW = 2*WIDTH + $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic             out_valid,
  output logic [OW-1:0]    SUM_OUT
);
  logic [WIDTH-1:0]   x_q [TAPS];
  logic [WIDTH-1:0]   x_d [TAPS];
  logic [WIDTH-1:0]   c_q [TAPS];
  logic [WIDTH-1:0]   c_d [TAPS];
  logic [2*WIDTH-1:0] p_q [TAPS];
  logic [2*WIDTH-1:0] p_d [TAPS];
  logic [OW-1:0]      sum_q, sum_d, acc;
  logic [2:0]         v_q, v_d;
  // v_q[0]: delay line just took a sample, v_q[1]: products valid, v_q[2]: sum valid
  always_comb begin
    v_d = flush ? 3'b000 : {v_q[1:0], in_valid};
    x_d[0] = flush ? '0 : in_valid ? DATA_IN : x_q[0];
    acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (i > 0) x_d[i] = flush ? '0 : in_valid ? x_q[i-1] : x_q[i];
      c_d[i] = (coef_we && int'(coef_addr) == i) ? coef_data : c_q[i];
      p_d[i] = (v_q[0] && !flush) ? (2*WIDTH)'(c_q[i]) * (2*WIDTH)'(x_q[i]) : p_q[i];
      acc = acc + OW'(p_q[i]);
    end
    sum_d = (v_q[1] && !flush) ? acc : sum_q;
  end
  // state registers; reset clears everything so in-flight samples are lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '{default: '0};
      c_q   <= '{default: '0};
      p_q   <= '{default: '0};
      sum_q <= '0;
      v_q   <= '0;
    end else begin
      x_q   <= x_d;
      c_q   <= c_d;
      p_q   <= p_d;
      sum_q <= sum_d;
      v_q   <= v_d;
    end
  end
  assign out_valid = v_q[2];
  assign SUM_OUT   = sum_q;
endmodule

// File: tb/tb_fir_sop_pipe.sv
// tb_fir_sop_pipe: directed stimulus with queued expected results and a decoupled output monitor
module tb_fir_sop_pipe;
  logic       clk = 0, rst = 1, flush = 0, in_valid = 0, coef_we = 0, b_sel = 0;
  logic [3:0] DATA_IN = 0, coef_data = 0;
  logic [1:0] coef_addr = 0;
  logic       ova, ovb;
  logic [9:0] soa, sob;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int v; int t;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  fir_sop_pipe #(.WIDTH(4), .TAPS(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid & ~b_sel), .DATA_IN(DATA_IN),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ova), .SUM_OUT(soa));

  fir_sop_pipe #(.WIDTH(4), .TAPS(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid & b_sel), .DATA_IN(DATA_IN),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ovb), .SUM_OUT(sob));

  // free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitors: compare value and arrival edge of every output pulse
  always @(negedge clk) if (ova) begin
    if (qa.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_out_a actual=valid sum %0d required=no output (cycle %0d)", soa, cyc);
    end else begin
      ea = qa.pop_front();
      chk("sum_a", int'(soa), ea.v);
      chk("edge_a", cyc, ea.t);
    end
  end

  always @(negedge clk) if (ovb) begin
    if (qb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_out_b actual=valid sum %0d required=no output (cycle %0d)", sob, cyc);
    end else begin
      eb = qb.pop_front();
      chk("sum_b", int'(sob), eb.v);
      chk("edge_b", cyc, eb.t);
    end
  end

  task automatic drv(input logic iv, input int d, input logic we, input int a, input int cd,
                     input logic fl, input int ev);
    @(negedge clk);
    in_valid = iv; DATA_IN = 4'(d); coef_we = we; coef_addr = 2'(a); coef_data = 4'(cd); flush = fl;
    if (ev >= 0) begin
      if (b_sel) qb.push_back(exp_t'{ev, cyc + 3});
      else qa.push_back(exp_t'{ev, cyc + 3});
    end
  endtask

  task automatic smp(input int d, input int ev);
    drv(1, d, 0, 0, 0, 0, ev);
  endtask

  task automatic wr(input int a, input int cd);
    drv(0, 0, 1, a, cd, 0, -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, -1);
  endtask

  initial begin
    #2 rst = 0;
    #1 chk("reset_valid", int'(ova), 0);
    chk("reset_sum", int'(soa), 0);
    @(negedge clk) rst = 1;
    // impulse
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    smp(1, 1); smp(0, 2); smp(0, 3); smp(0, 4); smp(0, 0);
    idle(3);
    // gapped impulse
    smp(1, 1); idle(1); smp(0, 2); idle(1); smp(0, 3); idle(1); smp(0, 4); idle(1); smp(0, 0);
    idle(3);
    // full scale
    wr(0, 15); wr(1, 15); wr(2, 15); wr(3, 15);
    smp(15, 225); smp(15, 450); smp(15, 675); smp(15, 900);
    idle(3);
    // coefficient write timing against sample acceptance
    wr(0, 1); wr(1, 1); wr(2, 1); wr(3, 1);
    smp(2, 47); smp(2, 34); smp(2, 21); smp(2, 8);
    drv(1, 2, 1, 0, 5, 0, 16);
    wr(0, 1);
    smp(2, 8);
    wr(0, 5);
    idle(3);
    // flush drops the concurrent sample and cancels pending results; writes still land
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    smp(3, 21); smp(3, -1); smp(3, -1);
    drv(1, 7, 1, 3, 8, 1, -1);
    smp(1, 1); smp(0, 2); smp(0, 3); smp(0, 8);
    idle(3);
    // asynchronous reset with two samples in flight
    smp(1, -1); smp(1, -1);
    @(posedge clk);
    #2 rst = 0;
    #1 chk("midreset_valid", int'(ova), 0);
    chk("midreset_sum", int'(soa), 0);
    @(negedge clk);
    in_valid = 0; rst = 1;
    idle(5);
    wr(0, 1); smp(5, 5);
    idle(3);
    // three-tap instance: out-of-range address must not touch any coefficient
    b_sel = 1;
    wr(0, 1); wr(1, 1); wr(2, 1);
    smp(2, 2); smp(2, 4); smp(2, 6);
    wr(3, 9);
    smp(2, 6);
    idle(4);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
